// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/response bundle for the iterative multiply/divide unit
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiplier / restoring divider with sign fix-up
// Define MDU_FAST_MUL_EN to replace the multiply iteration with a single-cycle array product.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} stateT;

  stateT            state;
  logic [CW-1:0]    iterCnt;
  logic [WIDTH-1:0] opndReg;
  logic [DW-1:0]    accReg;
  logic             isDivReg;
  logic             negQReg;
  logic             negRReg;
  logic             rawReg;

  logic             signedOp;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH:0]   divDiff;
  logic [DW-1:0]    mulNext;
  logic [DW-1:0]    divNext;
  logic [DW-1:0]    accNeg;
  logic [WIDTH-1:0] quotNeg;
  logic [WIDTH-1:0] remNeg;
  logic             lastIter;

  // accReg is {partial product, multiplier} during MUL and {remainder, quotient} during DIV
  always_comb begin
    signedOp = ~bus.op[0];
    magA     = (signedOp && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    magB     = (signedOp && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    mulSum   = {1'b0, accReg[DW-1:WIDTH]} + {1'b0, opndReg};
    mulNext  = accReg[0] ? {mulSum, accReg[WIDTH-1:1]} : {1'b0, accReg[DW-1:1]};

    divShift = accReg[DW-1:WIDTH-1];
    divDiff  = divShift - {1'b0, opndReg};
    divNext  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], accReg[WIDTH-2:0], 1'b0}
                              : {divDiff[WIDTH-1:0], accReg[WIDTH-2:0], 1'b1};

    accNeg   = -accReg;
    quotNeg  = -accReg[WIDTH-1:0];
    remNeg   = -accReg[DW-1:WIDTH];
    lastIter = (iterCnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      iterCnt  <= '0;
      opndReg  <= '0;
      accReg   <= '0;
      isDivReg <= 1'b0;
      negQReg  <= 1'b0;
      negRReg  <= 1'b0;
      rawReg   <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          if (bus.start && !bus.cancel) begin
            isDivReg <= bus.op[1];
            negQReg  <= signedOp && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negRReg  <= signedOp && bus.a[WIDTH-1];
            rawReg   <= 1'b0;
            iterCnt  <= '0;
            if (bus.op[1]) begin
              if (bus.b == '0) begin
                // Divide by zero bypasses iteration with a fixed, unsigned result
                accReg <= {bus.a, {WIDTH{1'b1}}};
                rawReg <= 1'b1;
                state  <= FIX;
              end else begin
                accReg  <= {{WIDTH{1'b0}}, magA};
                opndReg <= magB;
                state   <= DIV;
              end
            end else begin
`ifdef MDU_FAST_MUL_EN
              accReg <= DW'(magA) * DW'(magB);
              state  <= FIX;
`else
              accReg  <= {{WIDTH{1'b0}}, magB};
              opndReg <= magA;
              state   <= MUL;
`endif
            end
          end
        end
        MUL: begin
          if (bus.cancel) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            accReg   <= mulNext;
            iterCnt  <= iterCnt + 1'b1;
            bus.busy <= 1'b1;
            if (lastIter) state <= FIX;
          end
        end
        DIV: begin
          if (bus.cancel) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            accReg   <= divNext;
            iterCnt  <= iterCnt + 1'b1;
            bus.busy <= 1'b1;
            if (lastIter) state <= FIX;
          end
        end
        FIX: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          if (!bus.cancel) begin
            bus.done <= 1'b1;
            if (rawReg) begin
              bus.hi <= accReg[DW-1:WIDTH];
              bus.lo <= accReg[WIDTH-1:0];
            end else if (isDivReg) begin
              bus.hi <= negRReg ? remNeg  : accReg[DW-1:WIDTH];
              bus.lo <= negQReg ? quotNeg : accReg[WIDTH-1:0];
            end else begin
              bus.hi <= negQReg ? accNeg[DW-1:WIDTH] : accReg[DW-1:WIDTH];
              bus.lo <= negQReg ? accNeg[WIDTH-1:0]  : accReg[WIDTH-1:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter (WIDTH=32)
module tb_mdu_iter;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_DONE = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_DONE = 33;
  localparam int MUL_BUSY = 32;
`endif

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  mdu_iter_if #(.WIDTH(32)) bus();
  mdu_iter #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int doneCyc, busyCnt, busyLast;
  logic [31:0] hiV, loV;

  // Edge 0 accepts; "cycle c" is sampled at the negedge after rising edge c.
  task automatic runOp(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input int cancelCyc, input int injCyc,
                       output int dc, output int bc, output int bl,
                       output logic [31:0] hv, output logic [31:0] lv);
    dc = -1; bc = 0; bl = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 32'hDEADBEEF; bus.b = 32'h0BADF00D;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.cancel = 1'b0;
      if (bus.busy) begin bc++; bl = c; end
      if (bus.done) dc = c;
      if (c == cancelCyc) bus.cancel = 1'b1;
      if (c == injCyc) begin bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd3; bus.b = 32'd4; end
    end
    hv = bus.hi; lv = bus.lo;
    bus.start = 1'b0; bus.cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    rst = 1'b0;
  endtask

  task automatic test_divu();
    runOp(OP_DIVU, 32'd100, 32'd7, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (doneCyc !== 33) begin errors++; $display("FAIL divu_done_cycle: got %0d expected 33", doneCyc); end
    checks++; if (busyCnt !== 32) begin errors++; $display("FAIL divu_busy_count: got %0d expected 32", busyCnt); end
    checks++; if (busyLast !== 32) begin errors++; $display("FAIL divu_busy_last: got %0d expected 32", busyLast); end
    checks++; if (loV !== 32'h0000000E) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", loV); end
    checks++; if (hiV !== 32'h00000002) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", hiV); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL divu_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_div_signed();
    runOp(OP_DIV, 32'hFFFFFFF9, 32'd2, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (doneCyc !== 33) begin errors++; $display("FAIL div_neg_done_cycle: got %0d expected 33", doneCyc); end
    checks++; if (loV !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected fffffffd", loV); end
    checks++; if (hiV !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected ffffffff", hiV); end
    runOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (loV !== 32'h80000000) begin errors++; $display("FAIL div_min_lo: got %h expected 80000000", loV); end
    checks++; if (hiV !== 32'h0) begin errors++; $display("FAIL div_min_hi: got %h expected 00000000", hiV); end
    runOp(OP_DIV, 32'd7, 32'hFFFFFFFE, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (loV !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo: got %h expected fffffffd", loV); end
    checks++; if (hiV !== 32'h00000001) begin errors++; $display("FAIL div_negb_hi: got %h expected 00000001", hiV); end
    runOp(OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (loV !== 32'h00000003) begin errors++; $display("FAIL div_bothneg_lo: got %h expected 00000003", loV); end
    checks++; if (hiV !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_bothneg_hi: got %h expected ffffffff", hiV); end
  endtask

  task automatic test_mult();
    runOp(OP_MULT, 32'hFFFFFFFD, 32'd5, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (doneCyc !== MUL_DONE) begin errors++; $display("FAIL mult_done_cycle: got %0d expected %0d", doneCyc, MUL_DONE); end
    checks++; if (busyCnt !== MUL_BUSY) begin errors++; $display("FAIL mult_busy_count: got %0d expected %0d", busyCnt, MUL_BUSY); end
    checks++; if (hiV !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hiV); end
    checks++; if (loV !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_neg_lo: got %h expected fffffff1", loV); end
    runOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (hiV !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_max_hi: got %h expected fffffffe", hiV); end
    checks++; if (loV !== 32'h00000001) begin errors++; $display("FAIL multu_max_lo: got %h expected 00000001", loV); end
    runOp(OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if ({hiV, loV} !== 64'h0000_0000_0000_000F) begin errors++; $display("FAIL mult_bothneg: got %h%h expected 000000000000000f", hiV, loV); end
    runOp(OP_MULT, 32'h80000000, 32'h80000000, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if ({hiV, loV} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL mult_min_sq: got %h%h expected 4000000000000000", hiV, loV); end
    runOp(OP_MULTU, 32'h12345678, 32'h10, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if ({hiV, loV} !== 64'h0000_0001_2345_6780) begin errors++; $display("FAIL multu_shift: got %h%h expected 0000000123456780", hiV, loV); end
  endtask

  task automatic test_div_zero();
    runOp(OP_DIVU, 32'h12345678, 32'h0, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (doneCyc !== 1) begin errors++; $display("FAIL divz_done_cycle: got %0d expected 1", doneCyc); end
    checks++; if (busyCnt !== 0) begin errors++; $display("FAIL divz_busy_count: got %0d expected 0", busyCnt); end
    checks++; if (hiV !== 32'h12345678) begin errors++; $display("FAIL divz_hi: got %h expected 12345678", hiV); end
    checks++; if (loV !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_lo: got %h expected ffffffff", loV); end
    runOp(OP_DIV, 32'hFFFFFFFB, 32'h0, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if ({hiV, loV} !== 64'hFFFFFFFB_FFFFFFFF) begin errors++; $display("FAIL divz_signed: got %h%h expected fffffffbffffffff", hiV, loV); end
  endtask

  task automatic test_cancel();
    int bsy, dn;
    runOp(OP_DIVU, 32'd100, 32'd7, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    runOp(OP_DIVU, 32'h0000FFFF, 32'd3, 10, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (doneCyc !== -1) begin errors++; $display("FAIL cancel_div_no_done: got done at %0d expected none", doneCyc); end
    checks++; if (busyLast !== 10) begin errors++; $display("FAIL cancel_div_busy_last: got %0d expected 10", busyLast); end
    checks++; if ({hiV, loV} !== {32'd2, 32'd14}) begin errors++; $display("FAIL cancel_div_hold: got %h%h expected 000000020000000e", hiV, loV); end
    runOp(OP_DIVU, 32'h0000FFFF, 32'd3, 32, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (doneCyc !== -1) begin errors++; $display("FAIL cancel_fix_no_done: got done at %0d expected none", doneCyc); end
    checks++; if ({hiV, loV} !== {32'd2, 32'd14}) begin errors++; $display("FAIL cancel_fix_hold: got %h%h expected 000000020000000e", hiV, loV); end
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_DIVU; bus.a = 32'd9; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    bsy = 0; dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy) bsy++;
      if (bus.done) dn++;
    end
    checks++; if (bsy + dn !== 0) begin errors++; $display("FAIL cancel_idle_start: got busy %0d done %0d expected 0 0", bsy, dn); end
    checks++; if ({bus.hi, bus.lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL cancel_idle_hold: got %h%h expected 000000020000000e", bus.hi, bus.lo); end
  endtask

  task automatic test_ignored_start();
    runOp(OP_DIVU, 32'd1000, 32'd10, -1, 5, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (doneCyc !== 33) begin errors++; $display("FAIL ignstart_done_cycle: got %0d expected 33", doneCyc); end
    checks++; if ({hiV, loV} !== {32'd0, 32'd100}) begin errors++; $display("FAIL ignstart_result: got %h%h expected 0000000000000064", hiV, loV); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'hFFFFFF9C; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", bus.busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
    checks++; if ({bus.hi, bus.lo} !== 64'h0) begin errors++; $display("FAIL rstmid_hilo: got %h%h expected 0", bus.hi, bus.lo); end
    @(negedge clk);
    rst = 1'b0;
    runOp(OP_MULTU, 32'd6, 32'd7, -1, -1, doneCyc, busyCnt, busyLast, hiV, loV);
    checks++; if (doneCyc !== MUL_DONE) begin errors++; $display("FAIL rstmid_mul_done: got %0d expected %0d", doneCyc, MUL_DONE); end
    checks++; if (loV !== 32'd42) begin errors++; $display("FAIL rstmid_mul_lo: got %h expected 0000002a", loV); end
    checks++; if (hiV !== 32'd0) begin errors++; $display("FAIL rstmid_mul_hi: got %h expected 00000000", hiV); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_signed();
    test_mult();
    test_div_zero();
    test_cancel();
    test_ignored_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal values even, 8 to 64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 Port: op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port: a  input  WIDTH  multiplicand / dividend, captured at the accepting edge.
REQ-007 Port: b  input  WIDTH  multiplier / divisor, captured at the accepting edge.
REQ-008 Port: cancel  input  1  pipeline flush; aborts the operation in flight.
REQ-009 Port: busy  output  1  registered; stall request to the hazard unit.
REQ-010 Port: done  output  1  registered one-cycle pulse; hi/lo updated in the same cycle.
REQ-011 Port: hi  output  WIDTH  product upper half / remainder.
REQ-012 Port: lo  output  WIDTH  product lower half / quotient.

Function
REQ-013 FSM states: IDLE, MUL, DIV, FIX; an operation always ends with a return to IDLE.
REQ-014 IDLE with start=1 and cancel=0 shall latch a, b, op and go to MUL (op[1]=0) or DIV (op[1]=1); the accepting edge is cycle 0.
REQ-015 start in any state other than IDLE shall be ignored; the operands of an ignored start are not latched.
REQ-016 MUL shall run a radix-2 shift-add over magnitudes for exactly WIDTH cycles; DIV shall run restoring division over magnitudes for exactly WIDTH cycles; both then enter FIX.
REQ-017 FIX shall apply signs and write hi/lo, assert done, and return to IDLE; done and new hi/lo appear at cycle N = WIDTH+1.
REQ-018 busy shall be 1 from cycle 1 through cycle N-1 and 0 in the done cycle.
REQ-019 Signed ops (MULT, DIV) shall take operand magnitudes; unsigned ops shall use operands as-is.
REQ-020 MULT/MULTU: {hi,lo} shall equal the full 2*WIDTH-bit product; it is negated for MULT when the operand signs differ.
REQ-021 DIV/DIVU: lo=quotient, hi=remainder; for DIV the quotient is negative when the operand signs differ and the remainder takes the dividend's sign.
REQ-022 DIV of the most-negative value by -1 shall give lo=most-negative value, hi=0.
REQ-023 Divide by zero (b=0) shall skip iteration: FIX at cycle 1, done at cycle 1, hi=a, lo=all ones, busy never asserted.
REQ-024 cancel=1 in MUL, DIV or FIX shall return the FSM to IDLE at the next edge; done stays 0, hi/lo are unchanged, busy falls at that edge.
REQ-025 cancel=1 and start=1 together in IDLE: start shall be ignored.
REQ-026 hi/lo shall hold their last written value between operations; only a completing FIX writes them.

Reset
REQ-027 rst=1 shall immediately force state=IDLE and busy=0, done=0, hi=0, lo=0, and clear internal iteration counters and operand registers, regardless of clk.
REQ-028 rst asserted mid-operation shall abandon the operation; the first start after rst deassertion shall be accepted normally.

Configuration
REQ-029 Macro MDU_FAST_MUL_EN: when defined, MULT/MULTU shall use a single-cycle array product: FIX at cycle 1, done at cycle 1, busy never asserted, and no MUL iteration.
REQ-030 When MDU_FAST_MUL_EN is undefined, multiplies shall use the iterative path with N=WIDTH+1; division timing is identical in both builds.

Verification (WIDTH=32)
REQ-031 DIVU a=100 b=7 -> busy cycles 1..32; done at cycle 33; lo=0x0000000E, hi=0x00000002.
REQ-032 DIV a=0xFFFFFFF9 (-7) b=2 -> at cycle 33 lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; done at cycle 33 without MDU_FAST_MUL_EN, cycle 1 with it; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 DIVU a=0x12345678 b=0 -> done at cycle 1, hi=0x12345678, lo=0xFFFFFFFF, busy stays 0.
REQ-035 Start DIVU, cancel at cycle 10 -> busy=0 from cycle 11, no done, hi/lo keep prior values; a start pulse at cycle 5 of a running op is ignored and does not alter the result.
REQ-036 Assert rst asynchronously at cycle 15 of a DIV -> all outputs 0 immediately; a new MULTU 6*7 then yields lo=42, hi=0.
